serial_word_tx: RTL and testbench
=================================

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word length in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port data_in, input, WIDTH bits, the parallel word to transmit.
REQ-005 The block SHALL have port neg_in, input, 1 bit; 1 means transmit the two's complement of data_in, 0 means transmit data_in unchanged.
REQ-006 The block SHALL have port load_valid, input, 1 bit, meaning data_in and neg_in are offered.
REQ-007 The block SHALL have port load_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-008 The block SHALL have port ser_out, output, 1 bit, the serial data bit, sent LSB first.
REQ-009 The block SHALL have port ser_valid, output, 1 bit, meaning ser_out carries a word bit this cycle.
REQ-010 The block SHALL have port sow, output, 1 bit, high on the first (LSB) bit of a word.
REQ-011 The block SHALL have port eow, output, 1 bit, high on the last (MSB) bit of a word.
REQ-012 The block SHALL have port ovf, output, 1 bit, the negation overflow flag, valid only when eow is high.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-014 In IDLE, load_ready SHALL be 1, and ser_valid, sow, eow and ovf SHALL be 0.
REQ-015 A transfer SHALL occur on a rising edge with load_valid=1 and load_ready=1; the block captures data_in and neg_in, clears the bit counter and the seen_one flag, and enters SHIFT.
REQ-016 Bit 0 SHALL appear on ser_out in the cycle after the transfer edge (latency 1 cycle), with ser_valid=1 and sow=1.
REQ-017 In SHIFT, one bit SHALL be emitted per cycle for WIDTH consecutive cycles: bit i in cycle i, no gaps, ser_valid=1 throughout.
REQ-018 Each emitted bit SHALL be: neg=0 -> ser_out = bit i; neg=1 -> ser_out = seen_one ? ~bit i : bit i.
REQ-019 seen_one SHALL be set after any emitted cycle whose original bit is 1 (copy through first 1, invert thereafter).
REQ-020 eow SHALL be 1 in cycle WIDTH-1 of the word; the counter wraps to 0 after it.
REQ-021 In the eow cycle, ovf SHALL be 1 iff neg=1 and the captured word is 1 followed by WIDTH-1 zeros (most negative value); otherwise 0.
REQ-022 load_ready SHALL be 1 during the eow cycle; a transfer on that edge starts the next word back-to-back, with the next sow in the following cycle and no idle gap.
REQ-023 With no transfer at the eow edge, the FSM SHALL return to IDLE, and ser_valid SHALL be 0 in the following cycle.
REQ-024 load_ready SHALL be 0 in all SHIFT cycles except the eow cycle; load_valid, data_in and neg_in SHALL be ignored while load_ready=0.
REQ-025 Changes to data_in or neg_in after the transfer edge SHALL NOT affect the word in flight.
REQ-026 A neg=1 word of all zeros SHALL emit WIDTH zeros with ovf=0.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, without waiting for a clock edge, and SHALL clear the counter, shift register and seen_one.
REQ-028 During reset, the outputs SHALL be: ser_out=0, ser_valid=0, sow=0, eow=0, ovf=0, load_ready=0.
REQ-029 load_ready SHALL rise on the first rising edge after rst returns to 1.
REQ-030 Asserting reset mid-word SHALL abort the word, and no partial eow SHALL be emitted.
REQ-031 After reset release, a new transfer SHALL start cleanly at bit 0.

Verification
REQ-032 The bench SHALL cover: WIDTH=8, data_in=0x06, neg=0 -> ser_out 0,1,1,0,0,0,0,0; sow in cycle 0, eow in cycle 7, ovf=0.
REQ-033 The bench SHALL cover: data_in=0x06, neg=1 -> ser_out 0,1,0,1,1,1,1,1 (0xFA), ovf=0.
REQ-034 The bench SHALL cover: data_in=0x80, neg=1 -> ser_out 0,0,0,0,0,0,0,1 (0x80), ovf=1 in the eow cycle.
REQ-035 The bench SHALL cover: two transfers back-to-back (0xFF neg=0, then 0x01 neg=1) -> 16 contiguous ser_valid cycles, the second word reading 1,1,1,1,1,1,1,1 with sow in cycle 8.
REQ-036 The bench SHALL cover: rst=0 pulsed asynchronously after bit 3 of a word -> ser_valid=0 immediately, no eow, load_ready=1 on the first edge after release, and a following 0x05 neg=0 word emitting 1,0,1,0,0,0,0,0.
REQ-037 The bench SHALL cover: load_valid held 1 with changing data_in during SHIFT -> the in-flight word is unchanged, and only the value present at the eow edge is accepted.

Source files
------------

// File: rtl/serial_word_tx_if.sv
// Handshake bundle for serial_word_tx: parallel word load on one side,
// serial bit stream with framing and overflow flags on the other.
interface serial_word_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             neg_in;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             sow;
    logic             eow;
    logic             ovf;

    modport master (
        output data_in, neg_in, load_valid,
        input  load_ready, ser_out, ser_valid, sow, eow, ovf
    );

    modport slave (
        input  data_in, neg_in, load_valid,
        output load_ready, ser_out, ser_valid, sow, eow, ovf
    );
endinterface

// File: rtl/serial_word_tx.sv
// Serialises a WIDTH-bit word LSB first, optionally as its two's complement,
// using the copy-through-first-one / invert-thereafter rule.
module serial_word_tx #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_word_tx_if.slave   bus
);
    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             seen_one;
    logic             most_neg;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             sow;
    logic             eow;
    logic             ovf;

    logic             transfer;
    logic             next_seen;
    logic [CW-1:0]    cnt_next;

    // shreg[0] is the bit currently on ser_out; shreg[1] is the one emitted next.
    assign transfer  = bus.load_valid & load_ready;
    assign next_seen = seen_one | shreg[0];
    assign cnt_next  = cnt + 1'b1;

    // A transfer always wins: load_ready is only high in IDLE or on the eow
    // cycle, so one branch covers both the first word and back-to-back words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            seen_one   <= 1'b0;
            most_neg   <= 1'b0;
            load_ready <= 1'b0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            sow        <= 1'b0;
            eow        <= 1'b0;
            ovf        <= 1'b0;
        end else if (transfer) begin
            state      <= SHIFT;
            shreg      <= bus.data_in;
            neg        <= bus.neg_in;
            most_neg   <= bus.neg_in && (bus.data_in == MOST_NEG);
            cnt        <= '0;
            seen_one   <= 1'b0;
            ser_out    <= bus.data_in[0];
            ser_valid  <= 1'b1;
            sow        <= 1'b1;
            eow        <= 1'b0;
            ovf        <= 1'b0;
            load_ready <= 1'b0;
        end else if (state == SHIFT && cnt != LAST) begin
            shreg      <= shreg >> 1;
            seen_one   <= next_seen;
            cnt        <= cnt_next;
            ser_out    <= shreg[1] ^ (neg & next_seen);
            ser_valid  <= 1'b1;
            sow        <= 1'b0;
            eow        <= (cnt_next == LAST);
            ovf        <= (cnt_next == LAST) & most_neg;
            load_ready <= (cnt_next == LAST);
        end else begin
            state      <= IDLE;
            cnt        <= '0;
            seen_one   <= 1'b0;
            load_ready <= 1'b1;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            sow        <= 1'b0;
            eow        <= 1'b0;
            ovf        <= 1'b0;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.ser_out    = ser_out;
    assign bus.ser_valid  = ser_valid;
    assign bus.sow        = sow;
    assign bus.eow        = eow;
    assign bus.ovf        = ovf;
endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: directed words plus random traffic, checked each
// cycle against a per-word expected-bit queue built from two's complement arithmetic.
module tb_serial_word_tx;
    localparam int               WIDTH    = 8;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic rdy;
        logic vld;
        logic dat;
        logic sow;
        logic eow;
        logic ovf;
        logic in_rst;
    } exp_t;

    localparam exp_t RESET_EXP = '{rdy: 1'b0, vld: 1'b0, dat: 1'b0, sow: 1'b0,
                                   eow: 1'b0, ovf: 1'b0, in_rst: 1'b1};
    localparam exp_t IDLE_EXP  = '{rdy: 1'b1, vld: 1'b0, dat: 1'b0, sow: 1'b0,
                                   eow: 1'b0, ovf: 1'b0, in_rst: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;

    serial_word_tx_if #(.WIDTH(WIDTH)) bus ();

    serial_word_tx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t             exp_q[$];
    exp_t             cur;
    int               pass_count  = 0;
    int               fail_count  = 0;
    int               total_count = 0;
    logic [WIDTH-1:0] cap_word    = '0;
    logic [WIDTH-1:0] last_word   = '0;
    int               valid_run   = 0;
    int               max_run     = 0;

    task automatic checkSig(input string tag, input logic obs, input logic expv);
        total_count++;
        assert (obs === expv) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic checkWord(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] expv);
        total_count++;
        assert (obs === expv) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int expv);
        total_count++;
        assert (obs == expv) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Compare all outputs against the expected cycle and reassemble words.
    task automatic checkOutput(input string tag);
        checkSig({tag, ".load_ready"}, bus.load_ready, cur.rdy);
        checkSig({tag, ".ser_valid"},  bus.ser_valid,  cur.vld);
        checkSig({tag, ".sow"},        bus.sow,        cur.sow);
        checkSig({tag, ".eow"},        bus.eow,        cur.eow);
        checkSig({tag, ".ovf"},        bus.ovf,        cur.ovf);
        if (cur.vld || cur.in_rst)
            checkSig({tag, ".ser_out"}, bus.ser_out, cur.dat);
        if (bus.ser_valid === 1'b1) begin
            cap_word = {bus.ser_out, cap_word[WIDTH-1:1]};
            valid_run++;
            if (bus.eow === 1'b1)
                last_word = cap_word;
        end else begin
            valid_run = 0;
        end
        if (valid_run > max_run)
            max_run = valid_run;
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] din, input logic ng);
        logic [WIDTH-1:0] tx_val;
        exp_t             e;
        tx_val = ng ? WIDTH'(-int'(din)) : din;
        for (int i = 0; i < WIDTH; i++) begin
            e.rdy    = (i == WIDTH - 1);
            e.vld    = 1'b1;
            e.dat    = tx_val[i];
            e.sow    = (i == 0);
            e.eow    = (i == WIDTH - 1);
            e.ovf    = (i == WIDTH - 1) && ng && (din == MOST_NEG);
            e.in_rst = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic advance();
        if (rst === 1'b0) begin
            exp_q.delete();
            cur = RESET_EXP;
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = IDLE_EXP;
        end
    endtask

    // One cycle: check at the falling edge, drive, then let the model follow the rising edge.
    task automatic applyStimulus(input logic lv, input logic [WIDTH-1:0] din,
                                 input logic ng, input string tag);
        checkOutput(tag);
        bus.load_valid = lv;
        bus.data_in    = din;
        bus.neg_in     = ng;
        if (lv && cur.rdy && rst)
            pushWord(din, ng);
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, WIDTH'($urandom), 1'($urandom), tag);
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        bus.neg_in     = 1'b0;
        cur            = RESET_EXP;

        @(negedge clk);
        checkOutput("reset");
        #2 rst = 1'b1;
        @(posedge clk);
        advance();
        @(negedge clk);

        applyStimulus(1'b1, 8'h06, 1'b0, "w06");
        idleCycles(WIDTH, "w06");
        checkWord("w06.word", last_word, 8'h06);

        applyStimulus(1'b1, 8'h06, 1'b1, "w06n");
        idleCycles(WIDTH, "w06n");
        checkWord("w06n.word", last_word, 8'hFA);

        applyStimulus(1'b1, 8'h80, 1'b1, "w80n");
        idleCycles(WIDTH, "w80n");
        checkWord("w80n.word", last_word, 8'h80);

        applyStimulus(1'b1, 8'h00, 1'b1, "w00n");
        idleCycles(WIDTH, "w00n");
        checkWord("w00n.word", last_word, 8'h00);

        max_run = 0;
        applyStimulus(1'b1, 8'hFF, 1'b0, "b2b");
        idleCycles(WIDTH - 1, "b2b");
        applyStimulus(1'b1, 8'h01, 1'b1, "b2b");
        checkWord("b2b.first", last_word, 8'hFF);
        idleCycles(WIDTH + 1, "b2b");
        checkWord("b2b.second", last_word, 8'hFF);
        checkInt("b2b.run", max_run, 2 * WIDTH);

        applyStimulus(1'b1, 8'h3C, 1'b0, "hold");
        for (int i = 0; i < WIDTH - 1; i++)
            applyStimulus(1'b1, WIDTH'($urandom), 1'($urandom), "hold");
        applyStimulus(1'b1, 8'hC3, 1'b1, "hold");
        checkWord("hold.first", last_word, 8'h3C);
        idleCycles(WIDTH, "hold");
        checkWord("hold.second", last_word, 8'h3D);

        // Abort a word while bit 3 is on the line.
        applyStimulus(1'b1, 8'hA7, 1'b1, "abort");
        idleCycles(3, "abort");
        checkOutput("abort.bit3");
        #2 rst = 1'b0;
        #1;
        checkSig("async.ser_valid",  bus.ser_valid,  1'b0);
        checkSig("async.eow",        bus.eow,        1'b0);
        checkSig("async.load_ready", bus.load_ready, 1'b0);
        checkSig("async.ser_out",    bus.ser_out,    1'b0);
        exp_q.delete();
        cur = RESET_EXP;
        @(posedge clk);
        advance();
        @(negedge clk);
        checkOutput("rst_low");
        #2 rst = 1'b1;
        @(posedge clk);
        advance();
        @(negedge clk);
        applyStimulus(1'b1, 8'h05, 1'b0, "post_rst");
        idleCycles(WIDTH, "post_rst");
        checkWord("post_rst.word", last_word, 8'h05);

        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] d;
            int               sel;
            sel = $urandom_range(0, 5);
            d   = (sel == 0) ? MOST_NEG : (sel == 1) ? '0 : WIDTH'($urandom);
            applyStimulus($urandom_range(0, 2) != 0, d, 1'($urandom), "rand");
        end
        idleCycles(WIDTH + 2, "drain");

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
